uart_rx: RTL and testbench

- UART receive path, the counterpart to the transmit state machine.
- Oversamples the serial line rxd on bclk and validates the start bit at mid-bit.
- Shifts in DATA_BITS data bits LSB first and checks one stop bit.
- Transfers the assembled word to a receive data register. Flags ready / framing / overrun status to the host, which clears it with a one-cycle rd_ack strobe.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame defaults for the rx/tx paths.
package uart_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned BCT_W          = 4;
  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned OVERSAMPLE_DEF = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture to settle metastability before use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of an oversampled line into a data register with status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 bclk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdrf,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BCT_W-1:0] BCT_LAST = BCT_W'(DATA_BITS - 1);

  logic                 rxs;
  uart_state_e          state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [BCT_W-1:0]     bct, bct_next;
  logic [DATA_BITS-1:0] rsr, rsr_next;
  logic [DATA_BITS-1:0] rx_data_next;
  logic                 rdrf_next, framing_err_next, overrun_err_next;
  logic                 load;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (bclk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  // State, counters, shift register and host-visible registers
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bct         <= '0;
      rsr         <= '0;
      rx_data     <= '0;
      rdrf        <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bct         <= bct_next;
      rsr         <= rsr_next;
      rx_data     <= rx_data_next;
      rdrf        <= rdrf_next;
      framing_err <= framing_err_next;
      overrun_err <= overrun_err_next;
      rx_busy     <= (state_next != IDLE);
    end
  end

  // Next-state, sampling and status update; load beats a coincident rd_ack
  always_comb begin
    state_next       = state;
    cnt_next         = cnt + CNT_W'(1);
    bct_next         = bct;
    rsr_next         = rsr;
    load             = 1'b0;
    rx_data_next     = rx_data;
    rdrf_next        = rdrf;
    framing_err_next = framing_err;
    overrun_err_next = overrun_err;

    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rxs) state_next = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next   = '0;
          bct_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_next = '0;
          rsr_next = {rxs, rsr[DATA_BITS-1:1]};
          bct_next = bct + BCT_W'(1);
          if (bct == BCT_LAST) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_next   = '0;
          load       = 1'b1;
          state_next = rxs ? IDLE : BRK;
        end
      end
      BRK: begin
        cnt_next = '0;
        if (rxs) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    if (rd_ack && rdrf) begin
      rdrf_next        = 1'b0;
      framing_err_next = 1'b0;
      overrun_err_next = 1'b0;
    end

    if (load) begin
      rdrf_next        = 1'b1;
      framing_err_next = !rxs;
      if (!rdrf || rd_ack) rx_data_next = rsr;
      else                 overrun_err_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at default parameters.
module tb_uart_rx;

  localparam int unsigned DB = 8;
  localparam int unsigned OS = 8;
  // 2 synchronizer edges + 77 cycles from detection to rdrf visible
  localparam int unsigned LOAD_LAT = 79;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          fe;
    logic          oe;
  } exp_t;

  logic          bclk = 1'b0;
  logic          rst_n;
  logic          rxd;
  logic          rd_ack;
  logic [DB-1:0] rx_data;
  logic          rdrf, framing_err, overrun_err, rx_busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t_fall   = 0;
  logic rdrf_q   = 1'b0;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .bclk        (bclk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .rd_ack      (rd_ack),
    .rx_data     (rx_data),
    .rdrf        (rdrf),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 bclk = ~bclk;

  always @(posedge bclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each rdrf rising edge must match the oldest queued expectation
  always @(negedge bclk) begin
    if (rst_n === 1'b1 && rdrf === 1'b1 && rdrf_q === 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("framing_err", 32'(framing_err), 32'(e.fe));
        chk("overrun_err", 32'(overrun_err), 32'(e.oe));
        chk("load_latency", 32'(cyc - t_fall), 32'(LOAD_LAT));
      end
    end
    rdrf_q <= rdrf;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Callers sit 1 time unit after a rising edge; each bit lasts OS cycles
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (OS) @(posedge bclk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    @(posedge bclk);
    #1;
    t_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic pulse_ack();
    @(posedge bclk);
    #1 rd_ack = 1'b1;
    @(posedge bclk);
    #1 rd_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge bclk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rxd    = 1'b1;
    rd_ack = 1'b0;
    repeat (3) @(posedge bclk);
    #1;
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rdrf", 32'(rdrf), 32'h0);
    chk("rst_fe", 32'(framing_err), 32'h0);
    chk("rst_oe", 32'(overrun_err), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // Basic frame then acknowledge
    sb.push_back('{data: 8'h55, fe: 1'b0, oe: 1'b0});
    send_frame(8'h55, 1'b1);
    idle(3);
    chk("rdrf_held_55", 32'(rdrf), 32'h1);
    pulse_ack();
    chk("rdrf_after_ack", 32'(rdrf), 32'h0);

    // Two frames with an ack between them
    sb.push_back('{data: 8'hA3, fe: 1'b0, oe: 1'b0});
    send_frame(8'hA3, 1'b1);
    pulse_ack();
    sb.push_back('{data: 8'h3C, fe: 1'b0, oe: 1'b0});
    send_frame(8'h3C, 1'b1);
    pulse_ack();
    chk("rdrf_after_ack2", 32'(rdrf), 32'h0);
    idle(4);

    // Two-cycle glitch: false start rejected at mid-bit
    @(posedge bclk);
    #1 rxd = 1'b0;
    repeat (2) @(posedge bclk);
    #1 rxd = 1'b1;
    repeat (2) @(posedge bclk);
    #1;
    chk("glitch_busy_high", 32'(rx_busy), 32'h1);
    repeat (4) @(posedge bclk);
    #1;
    chk("glitch_busy_low", 32'(rx_busy), 32'h0);
    idle(20);
    chk("glitch_rdrf", 32'(rdrf), 32'h0);

    // Framing error followed by a held-low break
    sb.push_back('{data: 8'h81, fe: 1'b1, oe: 1'b0});
    send_frame(8'h81, 1'b0);
    rxd = 1'b0;
    repeat (40) @(posedge bclk);
    #1;
    chk("brk_busy", 32'(rx_busy), 32'h1);
    idle(4);
    chk("brk_exit_busy", 32'(rx_busy), 32'h0);
    idle(100);
    chk("brk_single_word", 32'(sb.size()), 32'h0);
    pulse_ack();
    chk("brk_fe_cleared", 32'(framing_err), 32'h0);

    // Overrun: second word dropped, then ack coincident with a load
    sb.push_back('{data: 8'h12, fe: 1'b0, oe: 1'b0});
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    chk("ovr_rx_data", 32'(rx_data), 32'h12);
    chk("ovr_flag", 32'(overrun_err), 32'h1);
    chk("ovr_rdrf", 32'(rdrf), 32'h1);
    fork
      send_frame(8'h56, 1'b1);
      begin
        @(posedge bclk);
        #1;
        repeat (LOAD_LAT - 1) @(posedge bclk);
        #1 rd_ack = 1'b1;
        @(posedge bclk);
        #1 rd_ack = 1'b0;
      end
    join
    chk("coinc_rx_data", 32'(rx_data), 32'h56);
    chk("coinc_rdrf", 32'(rdrf), 32'h1);
    chk("coinc_oe", 32'(overrun_err), 32'h0);
    chk("coinc_fe", 32'(framing_err), 32'h0);

    // Reset during data bit 4 of a frame (0x56 left unacked)
    @(posedge bclk);
    #1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b0;
    repeat (4) @(posedge bclk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rx_data", 32'(rx_data), 32'h0);
    chk("mid_rst_rdrf", 32'(rdrf), 32'h0);
    chk("mid_rst_oe_fe", 32'({overrun_err, framing_err}), 32'h0);
    chk("mid_rst_busy", 32'(rx_busy), 32'h0);
    rxd = 1'b1;
    repeat (3) @(posedge bclk);
    #1 rst_n = 1'b1;
    idle(5);
    sb.push_back('{data: 8'hF0, fe: 1'b0, oe: 1'b0});
    send_frame(8'hF0, 1'b1);
    pulse_ack();
    idle(20);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
